// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM stream reader: default widths and FSM state encoding.
package rom_stream_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register; payload is held while stalled.
module stream_out_reg #(
    parameter int unsigned W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // A load always wins; the caller only loads when the slot is empty or draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Walks COUNT consecutive ROM addresses from BASE and streams the registered words
// out over valid/ready, flagging the final word with out_last.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    remaining;
    logic                load;
    logic                accept;
    logic                cmd_go;
    logic                done_d;
    logic                last_word;
    logic [CNT_W-1:0]    count_sat;
    logic [DATA_W:0]     out_payload;

    assign rom_addr  = addr_q;
    assign accept    = out_valid && out_ready;
    assign last_word = (remaining == CNT_W'(1));
    assign count_sat = (count > DEPTH) ? DEPTH : count;
    assign out_data  = out_payload[DATA_W-1:0];
    assign out_last  = out_payload[DATA_W];

    // Next-state and strobe decode
    always_comb begin
        state_d = state;
        load    = 1'b0;
        cmd_go  = 1'b0;
        done_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    cmd_go  = 1'b1;
                    state_d = S_FETCH;
                end else if (start) begin
                    done_d  = 1'b1;
                end
            end
            S_FETCH: begin
                load = !out_valid || out_ready;
                if (load && last_word) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept && out_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != S_IDLE);
            done  <= done_d;
            if (cmd_go) begin
                addr_q    <= base;
                remaining <= count_sat;
            end else if (load) begin
                addr_q    <= addr_q + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    stream_out_reg #(
        .W(DATA_W + 1)
    ) u_out_reg (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_data({last_word, rom_data}),
        .ready    (out_ready),
        .valid    (out_valid),
        .data     (out_payload)
    );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: expected word sequences come from
// the address-walk rule (base+i mod 16, data = addr*10) and are consumed as words are accepted.
module tb_rom_stream_reader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] base;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int checks;
    int errors;

    rom_stream_reader #(
        .ADDR_W(4),
        .DATA_W(8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .base     (base),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    assign rom_data = 8'(rom_addr * 8'd10);

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_last"}, 32'(out_last), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    endtask

    // mode 0: ready always high, 1: ready toggles 1,0,1,0..., 2: random ready.
    // poke_at: cycle at which a second start is issued while busy (0 = never).
    task automatic run_cmd(input logic [3:0] b, input logic [4:0] c, input int mode, input int poke_at);
        logic [7:0] exp_q[$];
        logic [7:0] exp_w;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       prev_stall;
        logic       r;
        bit         finished;
        int         n;
        int         cyc;
        int         first_acc;
        int         last_acc;
        n = (int'(c) > 16) ? 16 : int'(c);
        for (int i = 0; i < n; i++) exp_q.push_back(8'(((int'(b) + i) % 16) * 10));

        @(negedge clock);
        start = 1'b1; base = b; count = c; out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        if (n == 0) begin
            check("noop_done", 32'(done), 32'd1);
            check("noop_busy", 32'(busy), 32'd0);
            check("noop_valid", 32'(out_valid), 32'd0);
            @(negedge clock);
            check("noop_done_once", 32'(done), 32'd0);
            check("noop_valid2", 32'(out_valid), 32'd0);
            return;
        end
        check("busy_rise", 32'(busy), 32'd1);
        check("lat_novalid", 32'(out_valid), 32'd0);

        cyc = 0; finished = 0; prev_stall = 0; first_acc = -1; last_acc = -1;
        prev_data = '0; prev_last = 1'b0;
        while (!finished && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (cyc == poke_at) begin
                start = 1'b1; base = ~b; count = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = 1'(cyc % 2);
            else r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (mode == 0 && cyc == 1) check("lat_valid", 32'(out_valid), 32'd1);
            if (out_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                    finished = 1;
                end else begin
                    exp_w = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(exp_w));
                    check("last", 32'(out_last), 32'(exp_q.size() == 0));
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                    finished = (exp_q.size() == 0);
                end
            end
            prev_stall = out_valid && !r;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        check("timeout", 32'(finished), 32'd1);

        @(negedge clock);
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_drop", 32'(busy), 32'd0);
        check("valid_drop", 32'(out_valid), 32'd0);
        if (mode == 0) check("throughput", 32'(last_acc - first_acc), 32'(n - 1));
        @(negedge clock);
        check("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        int acc;
        int guard;
        checks = 0; errors = 0;
        clock = 1'b0; reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_zero("reset");
        reset = 1'b0;

        run_cmd(4'd0, 5'd16, 0, 0);
        run_cmd(4'd14, 5'd4, 0, 0);
        run_cmd(4'd3, 5'd3, 1, 0);
        run_cmd(4'd9, 5'd0, 0, 0);
        run_cmd(4'd7, 5'd5, 0, 2);
        run_cmd(4'd11, 5'd6, 2, 3);

        // Reset after two accepted words abandons the command.
        @(negedge clock);
        start = 1'b1; base = 4'd5; count = 5'd8; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        acc = 0; guard = 0;
        while (acc < 2 && guard < 20) begin
            @(negedge clock);
            guard++;
            if (out_valid) begin
                check("rst_pre_data", 32'(out_data), 32'((5 + acc) * 10));
                acc++;
            end
        end
        check("rst_pre_timeout", 32'(acc), 32'd2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle_zero("midreset");
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_done", 32'(done), 32'd0);
        run_cmd(4'd0, 5'd1, 0, 0);

        run_cmd(4'd2, 5'd20, 0, 0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)),
                    int'($urandom_range(0, 2)), int'($urandom_range(1, 10)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
